fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction buffer directly downstream of the fetch stage and upstream of decode.
- Each cycle it accepts a packet of 0-4 contiguous fetched instructions with their branch-prediction info, and stores them in a circular FIFO.
- It presents up to DEQ_WIDTH oldest instructions per cycle to decode and decouples fetch bandwidth from decode back-pressure.
- It raises fetch_stall when a full 4-wide packet cannot be guaranteed space, and clears completely on a redirect flush.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 8.
- DEQ_WIDTH, 4, maximum instructions presented to decode per cycle; range 1..4.
- PTR_W, $clog2(DEPTH), pointer width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  redirect or mispredict; discards all contents.
- in_req  in  DECODE_REQUIRE[3:0]  fetch packet. Slot i holds pc, inst, predict_brunch_taken and predict_pc_addr; in_req[0].valid_number is the packet size.
- fetch_stall  out  1  high means the fetch packet this cycle is not accepted.
- out_entry  out  FQ_ENTRY[DEQ_WIDTH-1:0]  oldest entries; slot 0 is the oldest.
- out_valid  out  DEQ_WIDTH  thermometer mask of valid out_entry slots.
- dec_accept  in  3  number of presented entries decode consumes this cycle.
- count  out  PTR_W+1  current occupancy (debug and perf).

Behaviour:
- Reset (asynchronous, active-high): head=0, tail=0, count=0. While reset is asserted: out_valid=0, fetch_stall=0, out_entry contents are don't-care but driven to 0.
- The packet size n = in_req[0].valid_number is 0..4. Values above 4 are illegal; an assertion fires and the value is treated as 4.
- fetch_stall = (DEPTH - count) < 4, computed from registered count only. It has no combinational path from dec_accept or in_req.
- Enqueue occurs when fetch_stall=0 and flush=0:
  - in_req[0..n-1] is written in order to tail, tail+1, ... modulo DEPTH.
  - tail += n.
  - When n=0 the queue is unchanged.
- Presentation:
  - out_entry[k] = mem[head+k mod DEPTH].
  - out_valid[k] = (k < count).
  - Both are purely combinational from registered state.
  - Latency from enqueue to visibility is 1 cycle; there is no same-cycle bypass.
- Dequeue: d = min(dec_accept, count, DEQ_WIDTH); head += d.
  - dec_accept greater than the valid count is clamped, with no error.
  - Decode must not accept non-prefix slots; this is enforced by the clamp.
- count_next = count + enq_n - d. Simultaneous enqueue and dequeue in one cycle is legal.
  - Space is guaranteed by the stall rule, so overflow is impossible.
  - Underflow is impossible because of the clamp.
- flush has the highest priority. Next cycle head=tail=count=0; that cycle's enqueue and dequeue are both ignored. fetch_stall is still computed from the current count during the flush cycle.
- Wrap-around: pointers wrap modulo DEPTH. A packet that straddles index DEPTH-1 → 0 is written split across the boundary, with order preserved.
- Reset asserted mid-operation empties the queue immediately (asynchronous clear); any in-flight packet is lost.
- FQ_ENTRY drops valid_number; it keeps pc, inst, predict_brunch_taken and predict_pc_addr.

Decomposition:
- In the shared package (defines.svh): FQ_ENTRY typedef, FQ_DEPTH and FQ_DEQ_WIDTH constants.
- Reused existing types: REG_WIDTH, PC, bool, DECODE_REQUIRE.
- One sub-module, fq_ptr_ctrl: holds head, tail and count registers, the clamp and the stall computation, and outputs the write and read indices.
- The storage array and the read muxing live in fetch_queue itself.

Test Plan:
- Reset then idle: after rst, count=0, out_valid=0000, fetch_stall=0. A packet with n=4, pcs 0x100..0x10C, dec_accept=0 → next cycle count=4, out_valid=1111, out_entry[0].pc=0x100.
- Back-pressure: push four n=4 packets with dec_accept=0 → count=16, fetch_stall=1. A fifth packet (pc 0x200) is not written and count stays 16. Then dec_accept=4 → count=12, and the same cycle fetch_stall=0.
- Wrap: fill to 14, drain 14, enqueue n=4 from pc 0x300 → entries land at indices 14, 15, 0, 1. The outputs in order are 0x300, 0x304, 0x308, 0x30C.
- Simultaneous: count=6, enqueue n=3, dec_accept=2 → count=7. The oldest two are removed and the new three are appended after the existing four.
- Clamp: count=2, dec_accept=4 → d=2, count=0, out_valid=0000 next cycle.
- Flush priority: count=9 with flush=1, n=4 and dec_accept=3 in the same cycle → next cycle count=0 and out_valid=0. The following n=2 packet appears at out_entry[0..1].

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: fetch packet slots, queue entries and default sizing.
package fetch_queue_pkg;

  localparam int unsigned REG_WIDTH    = 32;
  localparam int unsigned FQ_DEPTH     = 16;
  localparam int unsigned FQ_DEQ_WIDTH = 4;
  localparam int unsigned FQ_ENQ_WIDTH = 4;

  typedef logic [REG_WIDTH-1:0] PC;
  typedef logic                 bool;

  // valid_number is only meaningful in slot 0, where it carries the packet size.
  typedef struct packed {
    logic [2:0]           valid_number;
    PC                    pc;
    logic [REG_WIDTH-1:0] inst;
    bool                  predict_brunch_taken;
    PC                    predict_pc_addr;
  } DECODE_REQUIRE;

  typedef struct packed {
    PC                    pc;
    logic [REG_WIDTH-1:0] inst;
    bool                  predict_brunch_taken;
    PC                    predict_pc_addr;
  } FQ_ENTRY;

  function automatic FQ_ENTRY to_fq_entry(DECODE_REQUIRE req);
    FQ_ENTRY e;
    e.pc                   = req.pc;
    e.inst                 = req.inst;
    e.predict_brunch_taken = req.predict_brunch_taken;
    e.predict_pc_addr      = req.predict_pc_addr;
    return e;
  endfunction

endpackage

// File: rtl/fq_ptr_ctrl.sv
// Head/tail/count bookkeeping for the fetch queue: dequeue clamp, stall and flush handling.
module fq_ptr_ctrl
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = FQ_DEPTH,
  parameter int unsigned DEQ_WIDTH = FQ_DEQ_WIDTH,
  parameter int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [2:0]       req_n_i,
  input  logic [2:0]       dec_accept_i,
  output logic [PTR_W-1:0] head_o,
  output logic [PTR_W-1:0] tail_o,
  output logic [PTR_W:0]   count_o,
  output logic [2:0]       enq_n_o,
  output logic             stall_o
);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  ptr_t       head_q, head_d, tail_q, tail_d;
  cnt_t       count_q, count_d;
  logic [2:0] req_n, deq_n;

  always_comb begin
    req_n   = (req_n_i > 3'd4) ? 3'd4 : req_n_i;
    // Registered count only: no path from in_req or dec_accept to the stall.
    stall_o = count_q > cnt_t'(DEPTH - FQ_ENQ_WIDTH);
    enq_n_o = (stall_o || flush_i) ? 3'd0 : req_n;

    deq_n = dec_accept_i;
    if (deq_n > 3'(DEQ_WIDTH)) deq_n = 3'(DEQ_WIDTH);
    if (cnt_t'(deq_n) > count_q) deq_n = 3'(count_q);

    head_d  = head_q + ptr_t'(deq_n);
    tail_d  = tail_q + ptr_t'(enq_n_o);
    count_d = count_q + cnt_t'(enq_n_o) - cnt_t'(deq_n);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;

  n_legal: assert property (@(posedge clk_i) disable iff (rst_i) req_n_i <= 3'd4);

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode; up to 4 in, DEQ_WIDTH out per cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = FQ_DEPTH,
  parameter int unsigned DEQ_WIDTH = FQ_DEQ_WIDTH,
  parameter int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  DECODE_REQUIRE [3:0]           in_req,
  output logic                          fetch_stall,
  output FQ_ENTRY       [DEQ_WIDTH-1:0] out_entry,
  output logic          [DEQ_WIDTH-1:0] out_valid,
  input  logic          [2:0]           dec_accept,
  output logic          [PTR_W:0]       count
);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  ptr_t       head, tail;
  logic [2:0] enq_n;
  FQ_ENTRY    mem_q [DEPTH];

  logic unused_vn;
  assign unused_vn = ^{in_req[1].valid_number, in_req[2].valid_number, in_req[3].valid_number};

  fq_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .DEQ_WIDTH (DEQ_WIDTH),
    .PTR_W     (PTR_W)
  ) u_ptr_ctrl (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .req_n_i      (in_req[0].valid_number),
    .dec_accept_i (dec_accept),
    .head_o       (head),
    .tail_o       (tail),
    .count_o      (count),
    .enq_n_o      (enq_n),
    .stall_o      (fetch_stall)
  );

  // Storage is not reset; out_valid alone qualifies the contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FQ_ENQ_WIDTH; i++) begin
      if (3'(i) < enq_n) mem_q[tail + ptr_t'(i)] <= to_fq_entry(in_req[i]);
    end
  end

  always_comb begin
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      out_entry[k] = rst ? '0 : mem_q[head + ptr_t'(k)];
      out_valid[k] = !rst && (count > cnt_t'(k));
    end
  end

endmodule
